// File: rtl/rv_defs_pkg.sv
// ---------------------------------------------------------------------------
// rv_defs: shared constants for the RV32E register file slice.
//   XLEN         register width in bits
//   NREGS_RV32E  architectural register count
//   dbg_state_e  debug dump FSM state encoding (IDLE=0, DUMP=1)
// ---------------------------------------------------------------------------
package rv_defs;

   localparam int XLEN        = 32;
   localparam int NREGS_RV32E = 16;

   typedef enum logic {
      DBG_IDLE = 1'b0,
      DBG_DUMP = 1'b1
   } dbg_state_e;

endpackage : rv_defs

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if: bundle of all register file signals except clk/rst.
//   write port   : wr_en, wr_addr, wr_data
//   read ports   : rd_addr (packed, AW per port), rd_data, rd_busy
//   scoreboard   : sb_set, sb_addr
//   debug dump   : dbg_req, dbg_ready, dbg_busy, dbg_valid, dbg_idx, dbg_data
// The slave modport is the register file side; master is the core/debug side.
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
   parameter int XLEN  = rv_defs::XLEN,
   parameter int NREGS = rv_defs::NREGS_RV32E,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [XLEN-1:0]      wr_data;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_busy;
   logic                 sb_set;
   logic [AW-1:0]        sb_addr;
   logic                 dbg_req;
   logic                 dbg_busy;
   logic                 dbg_valid;
   logic                 dbg_ready;
   logic [AW-1:0]        dbg_idx;
   logic [XLEN-1:0]      dbg_data;

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr, dbg_req, dbg_ready,
      output rd_data, rd_busy, dbg_busy, dbg_valid, dbg_idx, dbg_data
   );

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr, dbg_req, dbg_ready,
      input  rd_data, rd_busy, dbg_busy, dbg_valid, dbg_idx, dbg_data
   );

endinterface : regfile_sb_if

// File: rtl/regfile_dbg_dump.sv
// ---------------------------------------------------------------------------
// regfile_dbg_dump: streams every register out in index order over a
// valid/ready port.
//   clk, rst             clock, async active-high reset
//   dbg_req              start request, only honoured in IDLE
//   dbg_ready            consumer accepts the current beat
//   dbg_valid/dbg_busy   beat valid (identical signals)
//   dbg_idx/dbg_data     registered index and value of the current beat
//   cap_idx/cap_val      array peek: index to capture this cycle and its value
//                        (the parent folds in a same-cycle write)
// ---------------------------------------------------------------------------
module regfile_dbg_dump #(
   parameter int XLEN  = rv_defs::XLEN,
   parameter int NREGS = rv_defs::NREGS_RV32E,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            dbg_req,
   input  logic            dbg_ready,
   output logic            dbg_valid,
   output logic            dbg_busy,
   output logic [AW-1:0]   dbg_idx,
   output logic [XLEN-1:0] dbg_data,
   output logic [AW-1:0]   cap_idx,
   input  logic [XLEN-1:0] cap_val
);
   import rv_defs::*;

   dbg_state_e state, state_next;
   logic       capture;

   // NOTE: non-blocking assignments in clocked blocks so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DBG_IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      cap_idx    = '0;
      case (state)
         DBG_IDLE: begin
            if (dbg_req) begin
               state_next = DBG_DUMP;
               capture    = 1'b1;
            end
         end
         DBG_DUMP: begin
            if (dbg_ready) begin
               if (dbg_idx == AW'(NREGS - 1)) begin
                  state_next = DBG_IDLE;
               end else begin
                  capture = 1'b1;
                  cap_idx = dbg_idx + AW'(1);
               end
            end
         end
         default: state_next = DBG_IDLE;
      endcase
   end

   // Beat index and data only move on a capture, so they hold while stalled
   // even if the source register is rewritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_idx  <= '0;
         dbg_data <= '0;
      end else if (capture) begin
         dbg_idx  <= cap_idx;
         dbg_data <= cap_val;
      end
   end

   assign dbg_valid = (state == DBG_DUMP);
   assign dbg_busy  = dbg_valid;

endmodule : regfile_dbg_dump

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb: parametrised register file with load-pending scoreboard,
// optional write-to-read bypass and a debug dump port.
//   clk, rst   clock, async active-high reset
//   bus        regfile_sb_if.slave: write port, NRD read ports with busy
//              flags, scoreboard set port and the debug dump stream
// Register 0 is hardwired to zero and can never be marked busy.
// ---------------------------------------------------------------------------
module regfile_sb #(
   parameter int XLEN   = rv_defs::XLEN,
   parameter int NREGS  = rv_defs::NREGS_RV32E,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_sb_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy, busy_next;
   logic             wr_live;
   logic [AW-1:0]    cap_idx;
   logic [XLEN-1:0]  cap_val;

   // Writes to x0 are dropped everywhere: storage, busy clear and bypass.
   assign wr_live = bus.wr_en && (bus.wr_addr != '0);

   // Set is applied after clear, so a load issued in the same cycle as a
   // writeback to that register leaves it pending.
   always_comb begin
      busy_next = busy;
      if (wr_live) busy_next[bus.wr_addr] = 1'b0;
      if (bus.sb_set && (bus.sb_addr != '0)) busy_next[bus.sb_addr] = 1'b1;
   end

   // NOTE: the array is reset because every register must read zero after
   // reset; that costs a reset net per flop, so it is not a free choice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_live) regs[bus.wr_addr] <= bus.wr_data;
         busy <= busy_next;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;
      assign addr = bus.rd_addr[k*AW +: AW];
      assign hit  = (BYPASS != 0) && wr_live && (bus.wr_addr == addr);
      assign bus.rd_data[k*XLEN +: XLEN] = hit ? bus.wr_data : regs[addr];
      assign bus.rd_busy[k]              = hit ? 1'b0 : busy[addr];
   end

   // Dump captures always see a same-cycle write, whatever BYPASS is.
   assign cap_val = (wr_live && (bus.wr_addr == cap_idx)) ? bus.wr_data : regs[cap_idx];

   regfile_dbg_dump #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_dump (
      .clk       (clk),
      .rst       (rst),
      .dbg_req   (bus.dbg_req),
      .dbg_ready (bus.dbg_ready),
      .dbg_valid (bus.dbg_valid),
      .dbg_busy  (bus.dbg_busy),
      .dbg_idx   (bus.dbg_idx),
      .dbg_data  (bus.dbg_data),
      .cap_idx   (cap_idx),
      .cap_val   (cap_val)
   );

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb: self-checking bench for regfile_sb. Two instances share one
// stimulus stream: dut_b with BYPASS=1 and dut_n with BYPASS=0. Expected
// values come from an array model of the register file, scoreboard and dump.
// ---------------------------------------------------------------------------
module tb_regfile_sb;
   localparam int XL = 32;
   localparam int NR = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_sb_if #(.XLEN(XL), .NREGS(NR), .NRD(2)) bus_b ();
   regfile_sb_if #(.XLEN(XL), .NREGS(NR), .NRD(2)) bus_n ();

   regfile_sb #(.XLEN(XL), .NREGS(NR), .NRD(2), .BYPASS(1)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b)
   );
   regfile_sb #(.XLEN(XL), .NREGS(NR), .NRD(2), .BYPASS(0)) dut_n (
      .clk (clk), .rst (rst), .bus (bus_n)
   );

   assign bus_n.wr_en     = bus_b.wr_en;
   assign bus_n.wr_addr   = bus_b.wr_addr;
   assign bus_n.wr_data   = bus_b.wr_data;
   assign bus_n.rd_addr   = bus_b.rd_addr;
   assign bus_n.sb_set    = bus_b.sb_set;
   assign bus_n.sb_addr   = bus_b.sb_addr;
   assign bus_n.dbg_req   = bus_b.dbg_req;
   assign bus_n.dbg_ready = bus_b.dbg_ready;

   // reference model
   logic [XL-1:0] m_regs [NR];
   logic          m_busy [NR];
   bit            m_dump;
   int            m_idx;
   logic [XL-1:0] m_data;

   int errors = 0;
   int checks = 0;
   int beats;

   task automatic check(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_dump = 1'b0;
      m_idx  = 0;
      m_data = '0;
   endtask

   // Effect of one rising edge on the architectural state.
   task automatic model_edge();
      if (bus_b.wr_en && bus_b.wr_addr != 0) begin
         m_regs[bus_b.wr_addr] = bus_b.wr_data;
         m_busy[bus_b.wr_addr] = 1'b0;
      end
      if (bus_b.sb_set && bus_b.sb_addr != 0) m_busy[bus_b.sb_addr] = 1'b1;
      if (!m_dump) begin
         if (bus_b.dbg_req) begin
            m_dump = 1'b1;
            m_idx  = 0;
            m_data = '0;
         end
      end else if (bus_b.dbg_ready) begin
         if (m_idx == NR - 1) m_dump = 1'b0;
         else begin
            m_idx++;
            m_data = m_regs[m_idx];
         end
      end
   endtask

   // Compare every output of both instances against the model.
   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         int a;
         logic [XL-1:0] eb, en;
         logic          bb, bn;
         a  = int'(bus_b.rd_addr[k*4 +: 4]);
         en = m_regs[a];
         bn = m_busy[a];
         eb = en;
         bb = bn;
         if (bus_b.wr_en && int'(bus_b.wr_addr) == a && a != 0) begin
            eb = bus_b.wr_data;
            bb = 1'b0;
         end
         check($sformatf("byp_rd_data%0d[x%0d]", k, a), bus_b.rd_data[k*XL +: XL], eb);
         check($sformatf("byp_rd_busy%0d[x%0d]", k, a), 32'(bus_b.rd_busy[k]), 32'(bb));
         check($sformatf("nobyp_rd_data%0d[x%0d]", k, a), bus_n.rd_data[k*XL +: XL], en);
         check($sformatf("nobyp_rd_busy%0d[x%0d]", k, a), 32'(bus_n.rd_busy[k]), 32'(bn));
      end
      check("dbg_valid", 32'(bus_b.dbg_valid), 32'(m_dump));
      check("dbg_busy", 32'(bus_b.dbg_busy), 32'(m_dump));
      if (m_dump) begin
         check("dbg_idx", 32'(bus_b.dbg_idx), 32'(m_idx));
         check("dbg_data", bus_b.dbg_data, m_data);
      end
      if (bus_b.dbg_valid && bus_b.dbg_ready) beats++;
   endtask

   task automatic tick_check();
      @(negedge clk);
      compare_all();
   endtask

   task automatic tick_edge();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      #1;
   endtask

   task automatic cycle();
      tick_check();
      tick_edge();
   endtask

   task automatic idle_inputs();
      bus_b.wr_en     = 1'b0;
      bus_b.wr_addr   = '0;
      bus_b.wr_data   = '0;
      bus_b.sb_set    = 1'b0;
      bus_b.sb_addr   = '0;
      bus_b.dbg_req   = 1'b0;
      bus_b.dbg_ready = 1'b0;
   endtask

   task automatic rd(input int a0, input int a1);
      bus_b.rd_addr = {4'(a1), 4'(a0)};
   endtask

   initial begin
      bit done;
      model_reset();
      idle_inputs();
      rd(0, 0);
      rst = 1'b1;
      cycle();
      cycle();
      #1 rst = 1'b0;

      // reset state, every index on both ports
      for (int i = 0; i < NR; i++) begin
         rd(i, NR - 1 - i);
         cycle();
      end

      // x5 write: same-cycle with bypass, next cycle without
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd5; bus_b.wr_data = 32'hDEADBEEF;
      rd(5, 5);
      tick_check();
      check("x5_byp_same_cycle", bus_b.rd_data[31:0], 32'hDEADBEEF);
      check("x5_nobyp_same_cycle", bus_n.rd_data[31:0], 32'h0);
      tick_edge();
      idle_inputs();
      tick_check();
      check("x5_nobyp_next_cycle", bus_n.rd_data[63:32], 32'hDEADBEEF);
      tick_edge();

      // x0 is hardwired and never busy
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd0; bus_b.wr_data = 32'h12345678;
      bus_b.sb_set = 1'b1; bus_b.sb_addr = 4'd0;
      rd(0, 0);
      tick_check();
      check("x0_same_cycle", bus_b.rd_data[31:0], 32'h0);
      tick_edge();
      idle_inputs();
      tick_check();
      check("x0_later", bus_n.rd_data[63:32], 32'h0);
      check("x0_busy", 32'(bus_b.rd_busy), 32'h0);
      tick_edge();

      // scoreboard set, clear by write, set wins over clear
      bus_b.sb_set = 1'b1; bus_b.sb_addr = 4'd3;
      rd(3, 3);
      cycle();
      idle_inputs();
      tick_check();
      check("x3_busy_after_set", 32'(bus_b.rd_busy[0]), 32'h1);
      tick_edge();
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd3; bus_b.wr_data = 32'd7;
      tick_check();
      check("x3_busy_write_cycle", 32'(bus_b.rd_busy[1]), 32'h0);
      check("x3_data_write_cycle", bus_b.rd_data[63:32], 32'd7);
      tick_edge();
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd4; bus_b.wr_data = 32'd9;
      bus_b.sb_set = 1'b1; bus_b.sb_addr = 4'd4;
      rd(4, 3);
      cycle();
      idle_inputs();
      tick_check();
      check("x4_set_wins", 32'(bus_b.rd_busy[0]), 32'h1);
      tick_edge();

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         bus_b.wr_en   = 1'($urandom_range(0, 1));
         bus_b.wr_addr = 4'($urandom_range(0, NR - 1));
         bus_b.wr_data = $urandom;
         bus_b.sb_set  = ($urandom_range(0, 3) == 0);
         bus_b.sb_addr = 4'($urandom_range(0, NR - 1));
         if ($urandom_range(0, 3) == 0) rd(int'(bus_b.wr_addr), $urandom_range(0, NR - 1));
         else rd($urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
         cycle();
      end
      idle_inputs();

      // load xi = i*0x11
      for (int i = 1; i < NR; i++) begin
         bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'(i); bus_b.wr_data = 32'(i * 32'h11);
         rd(i, i - 1);
         cycle();
      end
      idle_inputs();

      // full-speed dump
      bus_b.dbg_req = 1'b1;
      bus_b.dbg_ready = 1'b1;
      beats = 0;
      cycle();
      bus_b.dbg_req = 1'b0;
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         rd($urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
         tick_check();
         if (bus_b.dbg_valid)
            check($sformatf("dump_beat_x%0d", bus_b.dbg_idx), bus_b.dbg_data,
                  32'(int'(bus_b.dbg_idx) * 32'h11));
         tick_edge();
         done = !m_dump;
      end
      check("dump_finished", 32'(done), 32'h1);
      check("dump_beats", 32'(beats), 32'd16);
      tick_check();
      check("dump_valid_low_after", 32'(bus_b.dbg_valid), 32'h0);
      check("dump_busy_low_after", 32'(bus_b.dbg_busy), 32'h0);
      tick_edge();

      // stalled dump with ready pattern 1,0,0; write x2 while beat 2 stalls
      bus_b.dbg_req = 1'b1;
      cycle();
      bus_b.dbg_req = 1'b0;
      beats = 0;
      done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
         bus_b.dbg_ready = (n % 3 == 0);
         bus_b.dbg_req   = (m_idx >= 4 && m_idx <= 6);
         bus_b.wr_en     = (m_idx == 2 && !bus_b.dbg_ready);
         bus_b.wr_addr   = 4'd2;
         bus_b.wr_data   = 32'hAA;
         tick_check();
         if (bus_b.dbg_valid && bus_b.dbg_idx == 4'd2)
            check("beat2_held", bus_b.dbg_data, 32'h22);
         tick_edge();
         done = !m_dump;
      end
      idle_inputs();
      check("stall_dump_finished", 32'(done), 32'h1);
      check("stall_dump_beats", 32'(beats), 32'd16);
      cycle();
      cycle();

      // reset in the middle of a dump
      bus_b.dbg_req = 1'b1;
      bus_b.dbg_ready = 1'b1;
      cycle();
      bus_b.dbg_req = 1'b0;
      for (int n = 0; n < 20 && m_idx != 7; n++) cycle();
      check("reached_beat7", 32'(m_idx), 32'd7);
      #1 rst = 1'b1;
      #1;
      model_reset();
      check("rst_dbg_valid", 32'(bus_b.dbg_valid), 32'h0);
      check("rst_dbg_busy", 32'(bus_b.dbg_busy), 32'h0);
      check("rst_dbg_idx", 32'(bus_b.dbg_idx), 32'h0);
      check("rst_dbg_data", bus_b.dbg_data, 32'h0);
      for (int i = 0; i < NR; i++) begin
         rd(i, NR - 1 - i);
         #1;
         check($sformatf("rst_x%0d_byp", i), bus_b.rd_data[31:0], 32'h0);
         check($sformatf("rst_x%0d_nobyp", NR - 1 - i), bus_n.rd_data[63:32], 32'h0);
      end
      cycle();
      #1 rst = 1'b0;
      for (int n = 0; n < 6; n++) begin
         tick_check();
         check("no_resume", 32'(bus_b.dbg_valid), 32'h0);
         tick_edge();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the RV32E core: configurable width, depth and read-port count, per-register write enable, optional same-cycle write-to-read bypass, and a load-pending scoreboard. It also provides a valid/ready debug dump port that streams every register out in index order. It sits between decode (read ports, scoreboard query) and writeback (write port, scoreboard clear). The debug port connects to the test/debug controller.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 16: register count; power of two, at least 2. AW = clog2(NREGS) is a local constant.
- NRD, 2: number of read ports.
- BYPASS, 1: 1 forwards same-cycle write data to read ports; 0 gives plain registered reads.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write index.
- wr_data  in  XLEN  write value.
- rd_addr  in  NRD*AW  packed read indices; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read values, combinational.
- rd_busy  out  NRD  scoreboard bit for each read index, combinational.
- sb_set  in  1  marks sb_addr as pending (load issued).
- sb_addr  in  AW  index to mark.
- dbg_req  in  1  starts a dump; single-cycle pulse or held.
- dbg_busy  out  1  high while a dump is in progress.
- dbg_valid  out  1  dump beat valid.
- dbg_ready  in  1  consumer accepts the beat.
- dbg_idx  out  AW  index of the current beat.
- dbg_data  out  XLEN  value of the current beat; registered.

## Operation
- Register 0 reads as 0 permanently; writes to it are discarded. sb_set to index 0 is ignored and busy[0] is always 0.
- Write: when wr_en=1 and wr_addr!=0, regs[wr_addr] takes wr_data at the edge. The same write clears busy[wr_addr].
- Scoreboard: sb_set=1 sets busy[sb_addr]. If sb_set and a clearing write hit the same index in the same cycle, the set wins and busy stays 1.
- Read, BYPASS=1: if wr_en=1, wr_addr==rd_addr_k and rd_addr_k!=0, then rd_data_k=wr_data and rd_busy_k=0. Otherwise rd_data_k=regs[rd_addr_k] and rd_busy_k=busy[rd_addr_k].
- Read, BYPASS=0: port k always returns stored state, with no forwarding.
- Debug FSM, states IDLE and DUMP:
  - IDLE: when dbg_req=1, move to DUMP with idx=0 and capture dbg_data<=regs[0]=0.
  - DUMP: dbg_valid=1. On dbg_valid&dbg_ready, if idx==NREGS-1, go to IDLE. Otherwise idx<=idx+1 and capture dbg_data<=regs[idx+1].
  - A capture takes wr_data when a write to that same index occurs in the capture cycle.
  - dbg_data and dbg_idx hold stable while valid&!ready, even if the register is written meanwhile.
  - dbg_req during DUMP is ignored. A new dump needs dbg_req high in IDLE.
- Normal reads and writes proceed unaffected during a dump.

## Timing
- Reset values: all regs 0, busy all 0, FSM in IDLE, dbg_valid=0, dbg_busy=0, dbg_idx=0, dbg_data=0. rd_data is 0 and rd_busy is 0 for every port.
- Reset asserted mid-dump aborts it immediately (async). The dump does not resume after reset.
- Write latency: visible on read ports in the same cycle (BYPASS=1) or the next cycle (BYPASS=0).
- sb_set visible on rd_busy in the next cycle.
- Dump timing:
  - dbg_req sampled at edge N gives dbg_valid=1 with idx 0 after edge N.
  - With dbg_ready held high, a dump takes exactly NREGS beats on consecutive cycles.
  - dbg_valid falls after the edge that accepts idx NREGS-1.
  - dbg_busy == dbg_valid.
- Width rule: indices wrap modulo NREGS, and no out-of-range index exists.

## Structure
- Shared package/header rv_defs holds:
  - XLEN=32 and NREGS_RV32E=16;
  - dump FSM state encodings (IDLE=0, DUMP=1).
- One sub-module, regfile_dbg_dump, holds the dump FSM, index counter and capture register. It reads the array through an index/data pair that includes the write-bypass term.
- The array, scoreboard and read muxes live in the top module, with a generate loop over the NRD read ports.

## Test plan
- Reset, then read all indices on both ports: rd_data=0 and rd_busy=0. Write x5=0xDEADBEEF, then read x5: BYPASS=1 gives 0xDEADBEEF in the write cycle; BYPASS=0 gives it in the next cycle.
- Write x0=0x12345678 and read x0 on both ports: 0 in the same cycle and in every later cycle. sb_set x0: rd_busy stays 0.
- sb_set x3, then read x3: busy=1 next cycle. Write x3=7 the following cycle: rd_busy=0 and rd_data=7 in that cycle. Simultaneous sb_set x4 with a write to x4: busy[4]=1 afterwards.
- Load xi=i*0x11 for all i, pulse dbg_req, hold dbg_ready=1: 16 consecutive beats with (idx i, data i*0x11, x0 giving 0), then dbg_valid=0 and dbg_busy=0.
- Dump with dbg_ready toggling 1,0,0,1…: each beat is held stable while ready=0. Write x2=0xAA while beat 2 is stalled: beat 2 data stays at its captured value. A second dbg_req during the dump is ignored.
- Assert rst at beat 7 of a dump: dbg_valid, dbg_busy and all regs go to 0 immediately. After release, no beat is produced until a new dbg_req.
